// File: rtl/nco_pkg.sv
// Shared encodings for the NCO sweep controller: plan modes, sequencer states
// and the default FCW width used by the DDS.
package nco_pkg;

    localparam int DEF_FCW_W = 15;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_UP     = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_FIN
    } state_t;

    // The reserved encoding behaves like a held single tone.
    function automatic logic holds_tone(input mode_t m);
        return (m == MODE_SINGLE) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/nco_settle_cnt.sv
// Settle counter: data_valid rises PIPE_LAT cycles after the last clear and
// drops in the same cycle that a new hop appears on the FCW.
module nco_settle_cnt #(
    parameter int PIPE_LAT = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic data_valid
);
    localparam int CNT_W = $clog2(PIPE_LAT + 1);

    logic [CNT_W-1:0] cnt;

    // clear is the next-cycle hop, so both registers line up with hop_strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            data_valid <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            data_valid <= 1'b0;
        end else if (cnt != CNT_W'(PIPE_LAT)) begin
            cnt        <= cnt + CNT_W'(1);
            data_valid <= (cnt == CNT_W'(PIPE_LAT - 1));
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-plan sequencer: accepts a sweep configuration and steps the DDS
// FCW through single-tone, up-sweep or triangle plans with per-tone dwell.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int FCW_W    = DEF_FCW_W,
    parameter int STEPS_W  = 8,
    parameter int DWELL_W  = 16,
    parameter int PIPE_LAT = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FCW_W-1:0]   cfg_fcw_start,
    input  logic [FCW_W-1:0]   cfg_fcw_step,
    input  logic [STEPS_W-1:0] cfg_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_repeat,
    input  logic               start,
    input  logic               abort,
    output logic [FCW_W-1:0]   fcw,
    output logic               initial_phase,
    output logic               hop_strobe,
    output logic               data_valid,
    output logic               busy,
    output logic               done
);
    localparam int IDX_W = STEPS_W + 1;

    state_t             state;
    logic [FCW_W-1:0]   sh_fcw_start;
    logic [FCW_W-1:0]   sh_fcw_step;
    logic [STEPS_W-1:0] sh_steps;
    logic [DWELL_W-1:0] sh_dwell;
    mode_t              sh_mode;
    logic               sh_repeat;

    logic [DWELL_W-1:0] dwell_cnt;
    logic [IDX_W-1:0]   tone_idx;
    logic               dir_up;

    logic               cfg_fire;
    logic [FCW_W-1:0]   plan_fcw;
    logic [DWELL_W-1:0] plan_dwell_raw;
    logic [DWELL_W-1:0] plan_dwell;
    logic [DWELL_W-1:0] reload_dwell;
    logic [IDX_W-1:0]   last_idx;
    logic               running;
    logic               expire;
    logic               more_tones;
    logic               begin_plan;
    logic               hop_next;
    logic               settle_clear;

    // A handshake in the same cycle as start bypasses the shadow registers.
    always_comb begin
        cfg_fire       = cfg_valid && cfg_ready;
        plan_fcw       = cfg_fire ? cfg_fcw_start : sh_fcw_start;
        plan_dwell_raw = cfg_fire ? cfg_dwell : sh_dwell;
        plan_dwell     = (plan_dwell_raw == '0) ? DWELL_W'(1) : plan_dwell_raw;
        reload_dwell   = (sh_dwell == '0) ? DWELL_W'(1) : sh_dwell;
        last_idx       = (sh_mode == MODE_TRI) ? {sh_steps, 1'b0} : {1'b0, sh_steps};
        running        = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_STEP);
        expire         = running && !holds_tone(sh_mode) && (dwell_cnt == DWELL_W'(1));
        more_tones     = (tone_idx != last_idx);
        begin_plan     = !abort && (((state == ST_IDLE) && start) ||
                                    ((state == ST_FIN) && sh_repeat));
        hop_next       = begin_plan || (!abort && expire && more_tones);
        settle_clear   = abort || hop_next || (state == ST_IDLE) ||
                         ((state == ST_FIN) && !sh_repeat);
    end

    // LOAD and STEP count as the first dwell cycle of their tone, so with a
    // dwell of one the expiry is taken straight out of those states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sh_fcw_start  <= '0;
            sh_fcw_step   <= '0;
            sh_steps      <= '0;
            sh_dwell      <= '0;
            sh_mode       <= MODE_SINGLE;
            sh_repeat     <= 1'b0;
            dwell_cnt     <= '0;
            tone_idx      <= '0;
            dir_up        <= 1'b1;
            fcw           <= '0;
            initial_phase <= 1'b0;
            hop_strobe    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_ready     <= 1'b1;
        end else begin
            initial_phase <= 1'b0;
            done          <= 1'b0;
            hop_strobe    <= hop_next;
            if (cfg_fire) begin
                sh_fcw_start <= cfg_fcw_start;
                sh_fcw_step  <= cfg_fcw_step;
                sh_steps     <= cfg_steps;
                sh_dwell     <= cfg_dwell;
                sh_mode      <= mode_t'(cfg_mode);
                sh_repeat    <= cfg_repeat;
            end
            if (abort) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE, ST_FIN: begin
                        if (begin_plan) begin
                            state         <= ST_LOAD;
                            busy          <= 1'b1;
                            cfg_ready     <= 1'b0;
                            fcw           <= plan_fcw;
                            initial_phase <= 1'b1;
                            dwell_cnt     <= plan_dwell;
                            tone_idx      <= '0;
                            dir_up        <= 1'b1;
                        end else if (state == ST_FIN) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end
                    end
                    default: begin
                        if (holds_tone(sh_mode)) begin
                            state <= ST_RUN;
                        end else if (expire) begin
                            if (more_tones) begin
                                state     <= ST_STEP;
                                fcw       <= dir_up ? fcw + sh_fcw_step : fcw - sh_fcw_step;
                                tone_idx  <= tone_idx + IDX_W'(1);
                                dwell_cnt <= reload_dwell;
                                if ((sh_mode == MODE_TRI) && dir_up &&
                                    (tone_idx + IDX_W'(1) == {1'b0, sh_steps}))
                                    dir_up <= 1'b0;
                            end else begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end
                        end else begin
                            state     <= ST_RUN;
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    nco_settle_cnt #(
        .PIPE_LAT(PIPE_LAT)
    ) u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (settle_clear),
        .data_valid(data_valid)
    );

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: hand-computed FCW traces, strobe counts
// and settle timing for each plan type, plus abort and reset corner cases.
module tb_nco_sweep_ctrl;

    localparam int FCW_W    = 15;
    localparam int STEPS_W  = 8;
    localparam int DWELL_W  = 16;
    localparam int PIPE_LAT = 24;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [FCW_W-1:0]   cfg_fcw_start = '0;
    logic [FCW_W-1:0]   cfg_fcw_step = '0;
    logic [STEPS_W-1:0] cfg_steps = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [1:0]         cfg_mode = '0;
    logic               cfg_repeat = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [FCW_W-1:0]   fcw;
    logic               initial_phase;
    logic               hop_strobe;
    logic               data_valid;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    nco_sweep_ctrl #(
        .FCW_W   (FCW_W),
        .STEPS_W (STEPS_W),
        .DWELL_W (DWELL_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_fcw_start(cfg_fcw_start),
        .cfg_fcw_step (cfg_fcw_step),
        .cfg_steps    (cfg_steps),
        .cfg_dwell    (cfg_dwell),
        .cfg_mode     (cfg_mode),
        .cfg_repeat   (cfg_repeat),
        .start        (start),
        .abort        (abort),
        .fcw          (fcw),
        .initial_phase(initial_phase),
        .hop_strobe   (hop_strobe),
        .data_valid   (data_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Flag order: cfg_ready, busy, done, data_valid, hop_strobe, initial_phase.
    function automatic logic [5:0] flags();
        return {cfg_ready, busy, done, data_valid, hop_strobe, initial_phase};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [FCW_W-1:0] fs, input logic [FCW_W-1:0] stp,
                                 input logic [STEPS_W-1:0] n, input logic [DWELL_W-1:0] d,
                                 input logic [1:0] m, input logic rep);
        @(negedge clk);
        cfg_fcw_start = fs;
        cfg_fcw_step  = stp;
        cfg_steps     = n;
        cfg_dwell     = d;
        cfg_mode      = m;
        cfg_repeat    = rep;
        cfg_valid     = 1'b1;
        @(negedge clk);
        cfg_valid     = 1'b0;
    endtask

    // Returns at the falling edge of the LOAD cycle.
    task automatic start_plan();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic abort_plan();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hold, dones, inits, hops, highs, rise, done_at;
        logic [FCW_W-1:0] exp_fcw;
        logic [FCW_W-1:0] tri_exp [5];
        tri_exp = '{15'h7FF0, 15'h0000, 15'h0010, 15'h0000, 15'h7FF0};

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_fcw", 32'(fcw), 32'h0);
        checkOutput("reset_flags", 32'(flags()), 32'(6'b100000));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single tone");
        applyStimulus(15'h0100, 15'h0000, 8'd0, 16'd5, 2'd0, 1'b0);
        start_plan();
        checkOutput("single_load_fcw", 32'(fcw), 32'h100);
        checkOutput("single_load_flags", 32'(flags()), 32'(6'b010011));
        hold = 0; dones = 0; rise = -1;
        for (int t = 0; t < 1000; t++) begin
            if (fcw == 15'h0100) hold++;
            if (done) dones++;
            if (data_valid && rise < 0) rise = t;
            @(negedge clk);
        end
        checkOutput("single_hold_cycles", 32'(hold), 32'd1000);
        checkOutput("single_no_done", 32'(dones), 32'd0);
        checkOutput("single_valid_rise", 32'(rise), 32'(PIPE_LAT));
        abort_plan();
        checkOutput("single_abort_flags", 32'(flags()), 32'(6'b100000));
        checkOutput("single_abort_fcw", 32'(fcw), 32'h100);

        $display("[TB] up-sweep");
        applyStimulus(15'h0010, 15'h0010, 8'd3, 16'd4, 2'd1, 1'b0);
        start_plan();
        hops = 0; dones = 0; done_at = -1;
        for (int t = 0; t < 20; t++) begin
            exp_fcw = (t < 16) ? FCW_W'(16 * (1 + t / 4)) : 15'h0040;
            checkOutput($sformatf("up_fcw_t%0d", t), 32'(fcw), 32'(exp_fcw));
            if (hop_strobe) hops++;
            if (done) begin dones++; done_at = t; end
            @(negedge clk);
        end
        checkOutput("up_hops", 32'(hops), 32'd4);
        checkOutput("up_done_count", 32'(dones), 32'd1);
        checkOutput("up_done_cycle", 32'(done_at), 32'd16);
        checkOutput("up_idle_flags", 32'(flags()), 32'(6'b100000));

        $display("[TB] triangle with wrap");
        applyStimulus(15'h7FF0, 15'h0010, 8'd2, 16'd2, 2'd2, 1'b0);
        start_plan();
        dones = 0; done_at = -1;
        for (int t = 0; t < 12; t++) begin
            exp_fcw = tri_exp[(t < 10) ? t / 2 : 4];
            checkOutput($sformatf("tri_fcw_t%0d", t), 32'(fcw), 32'(exp_fcw));
            if (done) begin dones++; done_at = t; end
            @(negedge clk);
        end
        checkOutput("tri_done_count", 32'(dones), 32'd1);
        checkOutput("tri_done_cycle", 32'(done_at), 32'd10);

        $display("[TB] zero dwell hops every cycle");
        applyStimulus(15'h0100, 15'h0001, 8'd2, 16'd0, 2'd1, 1'b0);
        start_plan();
        hops = 0; done_at = -1;
        for (int t = 0; t < 5; t++) begin
            exp_fcw = 15'h0100 + FCW_W'((t < 2) ? t : 2);
            checkOutput($sformatf("d0_fcw_t%0d", t), 32'(fcw), 32'(exp_fcw));
            if (hop_strobe) hops++;
            if (done) done_at = t;
            @(negedge clk);
        end
        checkOutput("d0_hops", 32'(hops), 32'd3);
        checkOutput("d0_done_cycle", 32'(done_at), 32'd3);

        $display("[TB] repeat and abort");
        applyStimulus(15'h0200, 15'h0100, 8'd1, 16'd3, 2'd1, 1'b1);
        start_plan();
        dones = 0; inits = 0;
        for (int t = 0; t < 21; t++) begin
            if (done) dones++;
            if (initial_phase) inits++;
            if (t == 3) checkOutput("rep_fcw_t3", 32'(fcw), 32'h300);
            if (t == 7) checkOutput("rep_fcw_t7", 32'(fcw), 32'h200);
            @(negedge clk);
        end
        checkOutput("rep_done_count", 32'(dones), 32'd3);
        checkOutput("rep_init_count", 32'(inits), 32'd3);
        @(negedge clk);
        checkOutput("rep_run_busy", 32'(busy), 32'd1);
        abort_plan();
        checkOutput("rep_abort_flags", 32'(flags()), 32'(6'b100000));
        checkOutput("rep_abort_fcw", 32'(fcw), 32'h200);
        dones = 0;
        for (int t = 0; t < 10; t++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        checkOutput("rep_post_abort_quiet", 32'(dones), 32'd0);

        $display("[TB] short dwell never settles");
        applyStimulus(15'h0010, 15'h0010, 8'd3, 16'd8, 2'd1, 1'b0);
        start_plan();
        highs = 0; hops = 0;
        for (int t = 0; t < 36; t++) begin
            if (data_valid) highs++;
            if (hop_strobe) hops++;
            @(negedge clk);
        end
        checkOutput("d8_valid_high", 32'(highs), 32'd0);
        checkOutput("d8_hops", 32'(hops), 32'd4);

        $display("[TB] long dwell settle timing");
        applyStimulus(15'h0010, 15'h0010, 8'd1, 16'd40, 2'd1, 1'b0);
        start_plan();
        for (int t = 0; t < 82; t++) begin
            case (t)
                23: checkOutput("d40_valid_t23", 32'(data_valid), 32'd0);
                24: checkOutput("d40_valid_t24", 32'(data_valid), 32'd1);
                39: checkOutput("d40_valid_t39", 32'(data_valid), 32'd1);
                40: begin
                    checkOutput("d40_valid_t40", 32'(data_valid), 32'd0);
                    checkOutput("d40_hop_t40", 32'(hop_strobe), 32'd1);
                end
                63: checkOutput("d40_valid_t63", 32'(data_valid), 32'd0);
                64: checkOutput("d40_valid_t64", 32'(data_valid), 32'd1);
                default: ;
            endcase
            @(negedge clk);
        end

        $display("[TB] config and start together");
        cfg_fcw_start = 15'h1234;
        cfg_fcw_step  = 15'h0000;
        cfg_steps     = 8'd0;
        cfg_dwell     = 16'd5;
        cfg_mode      = 2'd0;
        cfg_repeat    = 1'b0;
        cfg_valid     = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        checkOutput("same_cycle_fcw", 32'(fcw), 32'h1234);
        checkOutput("same_cycle_flags", 32'(flags()), 32'(6'b010011));
        abort_plan();

        $display("[TB] start with abort");
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_flags", 32'(flags()), 32'(6'b100000));
        checkOutput("start_abort_fcw", 32'(fcw), 32'h1234);

        $display("[TB] async reset mid-step");
        applyStimulus(15'h0500, 15'h0001, 8'd3, 16'd1, 2'd1, 1'b0);
        start_plan();
        @(negedge clk);
        checkOutput("step_fcw", 32'(fcw), 32'h501);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_fcw", 32'(fcw), 32'h0);
        checkOutput("async_reset_flags", 32'(flags()), 32'(6'b100000));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_plan();
        checkOutput("post_reset_cfg_fcw", 32'(fcw), 32'h0);
        checkOutput("post_reset_flags", 32'(flags()), 32'(6'b010011));
        abort_plan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
